// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory request/response, execute redirect,
// and the decode-facing head entry. The fetch unit takes the master view.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        advance;
  logic        fd_valid;
  logic [31:0] fd_instr;
  logic [31:0] fd_pc;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_en,
    input  redirect_pc,
    input  advance,
    output fd_valid,
    output fd_instr,
    output fd_pc
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_en,
    output redirect_pc,
    output advance,
    input  fd_valid,
    input  fd_instr,
    input  fd_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential fetches with credit-based flow
// control, pairs in-order responses with their request PC, buffers them for
// decode, and flushes on redirect. Responses to requests issued before a
// redirect or reset are counted as stale and dropped on arrival.
// BUF_DEPTH must be a power of two, 2 or more.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_W  = (CW+1)'(BUF_DEPTH);
  localparam logic [31:0]   RESET_AL = RESET_PC & 32'hFFFF_FFFC;

  // Architectural state
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q,    count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] stale_q,    stale_d;
  logic [AW-1:0] head_q,     head_d;
  logic [AW-1:0] tail_q,     tail_d;
  logic [AW-1:0] pq_rd_q,    pq_rd_d;

  // Storage: instruction buffer and outstanding-request PC queue
  logic [31:0] buf_instr_q [BUF_DEPTH];
  logic [31:0] buf_pc_q    [BUF_DEPTH];
  logic [31:0] pq_q        [BUF_DEPTH];

  // Per-cycle events
  logic          req_valid_s;
  logic          accept_s;
  logic          rsp_take_s;
  logic          rsp_stale_s;
  logic          rsp_good_s;
  logic          pop_s;
  logic          fd_valid_s;
  logic [CW:0]   occ_s;
  logic [CW-1:0] inflight_after_s;
  logic [AW-1:0] pq_wr_s;
  logic [31:0]   redirect_tgt_s;

  // Request credit, handshake and response classification
  always_comb begin
    occ_s            = {1'b0, count_q} + {1'b0, inflight_q};
    req_valid_s      = !rst && !bus.redirect_en && (occ_s < DEPTH_W);
    accept_s         = req_valid_s && bus.imem_req_ready;
    // A response with nothing outstanding is spurious and ignored entirely.
    rsp_take_s       = bus.imem_rsp_valid && (inflight_q != {CW{1'b0}});
    rsp_stale_s      = rsp_take_s && (stale_q != {CW{1'b0}});
    rsp_good_s       = rsp_take_s && (stale_q == {CW{1'b0}}) && !bus.redirect_en && !rst;
    fd_valid_s       = (count_q != {CW{1'b0}});
    pop_s            = bus.advance && fd_valid_s && !bus.redirect_en && !rst;
    inflight_after_s = inflight_q + CW'(accept_s) - CW'(rsp_take_s);
    // Write slot of the PC queue sits inflight entries past the read slot.
    pq_wr_s          = pq_rd_q + inflight_q[AW-1:0];
    redirect_tgt_s   = bus.redirect_pc & 32'hFFFF_FFFC;
  end

  // Next-state: reset outranks redirect, which outranks normal flow
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    inflight_d = inflight_after_s;
    stale_d    = stale_q;
    head_d     = head_q;
    tail_d     = tail_q;
    // Every accepted response, stale or not, retires its PC queue entry.
    pq_rd_d    = pq_rd_q + AW'(rsp_take_s);
    if (rst) begin
      // Requests still outstanding across reset are dropped when they return.
      fetch_pc_d = RESET_AL;
      count_d    = {CW{1'b0}};
      head_d     = {AW{1'b0}};
      tail_d     = {AW{1'b0}};
      stale_d    = inflight_after_s;
    end else if (bus.redirect_en) begin
      fetch_pc_d = redirect_tgt_s;
      count_d    = {CW{1'b0}};
      head_d     = {AW{1'b0}};
      tail_d     = {AW{1'b0}};
      stale_d    = inflight_after_s;
    end else begin
      fetch_pc_d = accept_s ? (fetch_pc_q + 32'd4) : fetch_pc_q;
      count_d    = count_q + CW'(rsp_good_s) - CW'(pop_s);
      head_d     = head_q + AW'(pop_s);
      tail_d     = tail_q + AW'(rsp_good_s);
      stale_d    = stale_q - CW'(rsp_stale_s);
    end
  end

  // Control state register with synchronous reset via next-state logic
  always_ff @(posedge clk) begin
    fetch_pc_q <= fetch_pc_d;
    count_q    <= count_d;
    inflight_q <= inflight_d;
    stale_q    <= stale_d;
    head_q     <= head_d;
    tail_q     <= tail_d;
    pq_rd_q    <= pq_rd_d;
  end

  // Data storage: PC of each accepted request, and paired buffer entries
  always_ff @(posedge clk) begin
    if (accept_s) begin
      pq_q[pq_wr_s] <= fetch_pc_q;
    end
    if (rsp_good_s) begin
      buf_instr_q[tail_q] <= bus.imem_rsp_data;
      buf_pc_q[tail_q]    <= pq_q[pq_rd_q];
    end
  end

  // Bus outputs; head entry reads as zero when the buffer is empty
  always_comb begin
    bus.imem_req_valid = req_valid_s;
    bus.imem_req_addr  = fetch_pc_q;
    bus.fd_valid       = fd_valid_s;
    if (fd_valid_s) begin
      bus.fd_instr = buf_instr_q[head_q];
      bus.fd_pc    = buf_pc_q[head_q];
    end else begin
      bus.fd_instr = 32'h0000_0000;
      bus.fd_pc    = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit. dut1 (RESET_PC=0) walks a
// per-cycle vector table; dut2 (RESET_PC=FFFF_FFF8) runs a zero-wait memory
// alongside to observe PC wrap.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if bus1();
  fetch_unit_if bus2();

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    logic        rst, ready, rsp_en, frc, adv, redir;
    logic [31:0] rpc;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_fdv;
    logic [31:0] e_fdpc;
  } vec_t;

  vec_t        vq[$];
  logic [31:0] memq[$];
  logic [31:0] acc2[$];
  logic [31:0] fdpc2[$];
  logic        from_mem;
  logic        log2_en;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic rdy, input logic ren, input logic frc,
                     input logic adv, input logic red, input logic [31:0] rpc,
                     input logic erv, input logic [31:0] eaddr, input logic efdv,
                     input logic [31:0] efdpc);
    vq.push_back('{r, rdy, ren, frc, adv, red, rpc, erv, eaddr, efdv, efdpc});
  endtask

  // One clock: sample handshakes, cross the edge, update the memory models.
  task automatic cycle();
    logic        acc1, fire1, a2v;
    logic [31:0] a1, a2;
    acc1  = bus1.imem_req_valid && bus1.imem_req_ready;
    a1    = bus1.imem_req_addr;
    fire1 = from_mem;
    a2v   = bus2.imem_req_valid;
    a2    = bus2.imem_req_addr;
    if (log2_en) begin
      if (a2v) acc2.push_back(a2);
      if (bus2.fd_valid) fdpc2.push_back(bus2.fd_pc);
    end
    @(posedge clk);
    #1;
    if (fire1) void'(memq.pop_front());
    if (acc1) memq.push_back(a1);
    bus2.imem_rsp_valid = a2v;
    bus2.imem_rsp_data  = mem_word(a2);
  endtask

  initial begin
    logic [31:0] e_acc2 [3];
    logic [31:0] e_fd2  [3];
    e_acc2 = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    e_fd2  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

    rst = 1'b1;
    from_mem = 1'b0;
    log2_en  = 1'b0;
    bus1.imem_req_ready = 1'b1; bus1.imem_rsp_valid = 1'b0; bus1.imem_rsp_data = 32'h0;
    bus1.redirect_en = 1'b0; bus1.redirect_pc = 32'h0; bus1.advance = 1'b0;
    bus2.imem_req_ready = 1'b1; bus2.imem_rsp_valid = 1'b0; bus2.imem_rsp_data = 32'h0;
    bus2.redirect_en = 1'b0; bus2.redirect_pc = 32'h0; bus2.advance = 1'b1;

    //   rst rdy ren frc adv red rpc            rv  addr            fdv fd_pc
    // startup stream, advance held
    add(0, 1, 1, 0, 1, 0, 32'h0,   1, 32'h0,   0, 32'h0);
    add(0, 1, 1, 0, 1, 0, 32'h0,   1, 32'h4,   0, 32'h0);
    add(0, 1, 1, 0, 1, 0, 32'h0,   1, 32'h8,   1, 32'h0);
    add(0, 1, 1, 0, 1, 0, 32'h0,   1, 32'hC,   1, 32'h4);
    add(0, 1, 1, 0, 1, 0, 32'h0,   1, 32'h10,  1, 32'h8);
    // mid-run reset with one request outstanding
    add(1, 1, 0, 0, 1, 0, 32'h0,   0, 32'h14,  1, 32'hC);
    // stale response after reset, then fill with advance low
    add(0, 1, 1, 0, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0);
    add(0, 1, 1, 0, 0, 0, 32'h0,   1, 32'h4,   0, 32'h0);
    add(0, 1, 1, 0, 0, 0, 32'h0,   1, 32'h8,   1, 32'h0);
    add(0, 1, 1, 0, 0, 0, 32'h0,   1, 32'hC,   1, 32'h0);
    add(0, 1, 1, 0, 0, 0, 32'h0,   0, 32'h10,  1, 32'h0);
    add(0, 1, 1, 1, 0, 0, 32'h0,   0, 32'h10,  1, 32'h0); // spurious rsp, inflight=0
    add(0, 1, 1, 0, 1, 0, 32'h0,   0, 32'h10,  1, 32'h0); // one pop, credit next cycle
    // memory stalls for 5 cycles
    add(0, 0, 1, 0, 0, 0, 32'h0,   1, 32'h10,  1, 32'h4);
    add(0, 0, 1, 0, 0, 0, 32'h0,   1, 32'h10,  1, 32'h4);
    add(0, 0, 1, 0, 0, 0, 32'h0,   1, 32'h10,  1, 32'h4);
    add(0, 0, 1, 0, 0, 0, 32'h0,   1, 32'h10,  1, 32'h4);
    add(0, 0, 1, 0, 0, 0, 32'h0,   1, 32'h10,  1, 32'h4);
    add(0, 1, 0, 0, 0, 0, 32'h0,   1, 32'h10,  1, 32'h4);
    // drain while building up requests in flight
    add(0, 1, 0, 0, 1, 0, 32'h0,   0, 32'h14,  1, 32'h4);
    add(0, 1, 0, 0, 1, 0, 32'h0,   1, 32'h14,  1, 32'h8);
    add(0, 1, 0, 0, 1, 0, 32'h0,   1, 32'h18,  1, 32'hC);
    // redirect to 0x41 with three requests outstanding
    add(0, 1, 0, 0, 1, 1, 32'h41,  0, 32'h1C,  0, 32'h0);
    add(0, 1, 1, 0, 1, 0, 32'h0,   1, 32'h40,  0, 32'h0);
    add(0, 1, 1, 0, 1, 0, 32'h0,   1, 32'h44,  0, 32'h0);
    add(0, 1, 1, 0, 1, 0, 32'h0,   1, 32'h48,  0, 32'h0);
    add(0, 1, 1, 0, 1, 0, 32'h0,   1, 32'h4C,  0, 32'h0);
    add(0, 1, 1, 0, 1, 0, 32'h0,   0, 32'h50,  1, 32'h40);
    // response in the same cycle as redirect
    add(0, 1, 1, 0, 1, 1, 32'h100, 0, 32'h50,  1, 32'h44);
    add(0, 1, 1, 0, 1, 0, 32'h0,   1, 32'h100, 0, 32'h0);
    add(0, 1, 1, 0, 1, 0, 32'h0,   1, 32'h104, 0, 32'h0);
    add(0, 1, 1, 0, 1, 0, 32'h0,   1, 32'h108, 1, 32'h100);
    // back-to-back redirects, last one wins
    add(0, 1, 0, 0, 1, 1, 32'h200, 0, 32'h10C, 1, 32'h104);
    add(0, 1, 0, 0, 1, 1, 32'h302, 0, 32'h200, 0, 32'h0);
    add(0, 1, 1, 0, 1, 0, 32'h0,   1, 32'h300, 0, 32'h0);
    add(0, 1, 1, 0, 1, 0, 32'h0,   1, 32'h304, 0, 32'h0);
    add(0, 1, 1, 0, 1, 0, 32'h0,   1, 32'h308, 1, 32'h300);

    // reset: two cycles, state checked in the second
    #1;
    cycle();
    chk("rst req_valid", {31'b0, bus1.imem_req_valid}, 32'h0);
    chk("rst req_addr",  bus1.imem_req_addr, 32'h0);
    chk("rst fd_valid",  {31'b0, bus1.fd_valid}, 32'h0);
    chk("rst fd_instr",  bus1.fd_instr, 32'h0);
    chk("rst fd_pc",     bus1.fd_pc, 32'h0);
    chk("rst2 req_valid", {31'b0, bus2.imem_req_valid}, 32'h0);
    chk("rst2 req_addr", bus2.imem_req_addr, 32'hFFFF_FFF8);
    cycle();

    for (int i = 0; i < vq.size(); i++) begin
      rst                 = vq[i].rst;
      bus1.imem_req_ready = vq[i].ready;
      bus1.advance        = vq[i].adv;
      bus1.redirect_en    = vq[i].redir;
      bus1.redirect_pc    = vq[i].rpc;
      from_mem            = vq[i].rsp_en && (memq.size() > 0);
      bus1.imem_rsp_valid = vq[i].frc || from_mem;
      bus1.imem_rsp_data  = from_mem ? mem_word(memq[0]) : 32'hDEAD_BEEF;
      log2_en             = (i < 5);
      #1;
      chk($sformatf("row%0d req_valid", i), {31'b0, bus1.imem_req_valid}, {31'b0, vq[i].e_rv});
      chk($sformatf("row%0d req_addr", i), bus1.imem_req_addr, vq[i].e_addr);
      chk($sformatf("row%0d fd_valid", i), {31'b0, bus1.fd_valid}, {31'b0, vq[i].e_fdv});
      chk($sformatf("row%0d fd_pc", i), bus1.fd_pc, vq[i].e_fdpc);
      chk($sformatf("row%0d fd_instr", i), bus1.fd_instr,
          vq[i].e_fdv ? mem_word(vq[i].e_fdpc) : 32'h0);
      cycle();
    end

    // wrap from RESET_PC=FFFF_FFF8
    chk("wrap req count", acc2.size(), 32'd5);
    chk("wrap fd count",  fdpc2.size(), 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("wrap req%0d", k), (k < acc2.size())  ? acc2[k]  : 32'hBAD0_0000, e_acc2[k]);
      chk($sformatf("wrap fd%0d", k),  (k < fdpc2.size()) ? fdpc2[k] : 32'hBAD0_0000, e_fd2[k]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL give the first fetch address after reset.
REQ-003 Parameter BUF_DEPTH, default 4, SHALL set the instruction buffer depth; legal values are powers of 2 and 2 or more.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 imem_req_valid  output  1  fetch request presented to instruction memory.
REQ-007 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-008 imem_req_addr  output  32  byte address of the request; bits [1:0] always 0.
REQ-009 imem_rsp_valid  input  1  instruction word returned; in order, at most one per cycle, at least 1 cycle after acceptance.
REQ-010 imem_rsp_data  input  32  returned instruction word.
REQ-011 redirect_en  input  1  branch taken from execute; changes fetch PC and flushes.
REQ-012 redirect_pc  input  32  target address; bits [1:0] are forced to 0 internally.
REQ-013 advance  input  1  decode stage consumes the head entry (pipeline advance).
REQ-014 fd_valid  output  1  head entry valid for the IF/ID register.
REQ-015 fd_instr  output  32  instruction word of the head entry.
REQ-016 fd_pc  output  32  address of the head entry.

Function
REQ-017 A request SHALL be accepted in any cycle where imem_req_valid and imem_req_ready are both 1; on acceptance, fetch_pc SHALL advance by +4 at the next edge, wrapping from 32'hFFFF_FFFC to 32'h0.
REQ-018 imem_req_valid SHALL equal !redirect_en && (count + inflight < BUF_DEPTH).
- count: buffer occupancy.
- inflight: accepted requests not yet answered, stale ones included.
- A pop in the same cycle does not free a credit until the next cycle.
REQ-019 imem_req_addr SHALL equal fetch_pc, and SHALL hold stable while imem_req_valid is 1 and imem_req_ready is 0.
REQ-020 The address of each accepted request SHALL be queued in order, so that every response is paired with its own PC.
REQ-021 A non-stale response SHALL be written as {imem_rsp_data, pc} to the buffer tail at the cycle's edge, so fd_valid rises the cycle after imem_rsp_valid.
REQ-022 fd_valid SHALL equal (count != 0), and fd_instr/fd_pc SHALL show the head entry combinationally from registers.
REQ-023 advance with fd_valid=1 SHALL pop the head; advance with fd_valid=0 SHALL be ignored.
REQ-024 A push and a pop in the same cycle SHALL leave count unchanged; overflow is impossible by REQ-018.
REQ-025 Redirect (redirect_en=1) SHALL have the following effects at the edge:
- fetch_pc becomes {redirect_pc[31:2],2'b00};
- the buffer is emptied (count=0, pointers reset);
- stale becomes the value of inflight after this cycle's response is accounted for;
- no request is accepted in that cycle.
REQ-026 A response arriving while stale>0 SHALL be discarded, and both stale and inflight SHALL be decremented.
REQ-027 A response in the same cycle as redirect_en SHALL be discarded, and advance in that cycle SHALL have no additional effect.
REQ-028 Back-to-back redirects SHALL each apply, with the last one winning fetch_pc and stale accumulating correctly.
REQ-029 imem_rsp_valid with inflight=0 SHALL be ignored, with no state change.
REQ-030 With a zero-wait memory (ready=1, rsp 1 cycle later), BUF_DEPTH>=3 and advance held at 1, throughput SHALL be sustained at one instruction per cycle.

Reset
REQ-031 With rst=1 at an edge, the following SHALL hold after that edge:
- fetch_pc=RESET_PC;
- count, inflight and stale are 0;
- fd_valid=0, fd_instr=0, fd_pc=0.
REQ-032 While rst=1, imem_req_valid SHALL be 0.
REQ-033 Responses arriving during reset, or after reset for requests issued before it, SHALL be discarded; this is done by setting stale=inflight on reset rather than 0 when inflight was nonzero (this overrides REQ-031 for stale).
REQ-034 Reset applied mid-operation SHALL take priority over redirect_en, advance and imem_rsp_valid.

Verification
REQ-035 Reset release, ready=1, 1-cycle rsp, advance=1 -> addresses 0x0,0x4,0x8...; fd_pc 0x0 on cycle 3 after release, then +4 every cycle.
REQ-036 advance=0 and ready=1 -> exactly 4 requests (0x0-0xC); fd_valid stays 1 with fd_pc=0x0; no request until advance pulses; after one pop, the next request is 0x10.
REQ-037 Two requests in flight (0x8, 0xC), then redirect_en with redirect_pc=0x41 -> both responses dropped; next request 0x40; first fd_pc after the redirect is 0x40.
REQ-038 Response and redirect in the same cycle -> response dropped, fd_valid=0 next cycle, fetch resumes at the target.
REQ-039 imem_req_ready=0 for 5 cycles with the address held at 0x10 -> address stable, no fetch_pc change; on ready=1, one acceptance, then 0x14.
REQ-040 RESET_PC=32'hFFFF_FFF8 -> request sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; fd_pc order matches.
